// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
//   Shared constants for the ID/EX boundary: default widths, the 4-bit ALU
//   control codes understood by the EX-stage ALU, and the opcode/funct
//   values the issue stage decodes.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int N_DEF          = 32;
    localparam int N_ALU_CTRL_DEF = 4;
    localparam int N_CNT_DEF      = 16;

    typedef logic [N_ALU_CTRL_DEF-1:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_AND = 4'b0000;
    localparam alu_ctrl_t ALU_OR  = 4'b0001;
    localparam alu_ctrl_t ALU_ADD = 4'b0010;
    localparam alu_ctrl_t ALU_SUB = 4'b0110;
    localparam alu_ctrl_t ALU_SLT = 4'b0111;
    localparam alu_ctrl_t ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

endpackage

// File: rtl/alu_issue_stage_if.sv
// ---------------------------------------------------------------------------
// alu_issue_if
//   Bundles the ID-side inputs, the EX handshake and the registered ALU
//   operands of the issue stage.
//   master : the issue stage (consumes id_*, ex_stall/ex_flush; drives
//            id_ready, ex_* and issue_count)
//   slave  : the surrounding pipeline (drives id_*, ex_stall/ex_flush)
// ---------------------------------------------------------------------------
interface alu_issue_if
    import pipeline_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int N_ALU_CTRL = N_ALU_CTRL_DEF,
    parameter int N_CNT      = N_CNT_DEF
);
    logic                  id_valid;
    logic [5:0]            id_opcode;
    logic [5:0]            id_funct;
    logic [N-1:0]          id_rs_data;
    logic [N-1:0]          id_rt_data;
    logic [15:0]           id_imm16;
    logic                  ex_stall;
    logic                  ex_flush;
    logic                  id_ready;
    logic                  ex_valid;
    logic [N_ALU_CTRL-1:0] ex_alu_ctrl;
    logic [N-1:0]          ex_op_a;
    logic [N-1:0]          ex_op_b;
    logic                  ex_illegal;
    logic [N_CNT-1:0]      issue_count;

    modport master (
        input  id_valid, id_opcode, id_funct, id_rs_data, id_rt_data, id_imm16,
               ex_stall, ex_flush,
        output id_ready, ex_valid, ex_alu_ctrl, ex_op_a, ex_op_b, ex_illegal,
               issue_count
    );

    modport slave (
        output id_valid, id_opcode, id_funct, id_rs_data, id_rt_data, id_imm16,
               ex_stall, ex_flush,
        input  id_ready, ex_valid, ex_alu_ctrl, ex_op_a, ex_op_b, ex_illegal,
               issue_count
    );
endinterface

// File: rtl/alu_issue_stage_decode.sv
// ---------------------------------------------------------------------------
// alu_issue_decode
//   Purely combinational opcode/funct decoder.
//   opcode_i, funct_i : instruction fields (funct used only for R-type)
//   alu_ctrl_o        : ALU control code
//   use_imm_o         : op_b comes from the immediate instead of rt
//   imm_sext_o        : immediate is sign-extended (else zero-extended)
//   slt_bias_o        : flip operand MSBs so the unsigned ALU compare is signed
//   illegal_o         : unsupported opcode/funct
// ---------------------------------------------------------------------------
module alu_issue_decode
    import pipeline_pkg::*;
#(
    parameter int N_ALU_CTRL = N_ALU_CTRL_DEF
) (
    input  logic [5:0]            opcode_i,
    input  logic [5:0]            funct_i,
    output logic [N_ALU_CTRL-1:0] alu_ctrl_o,
    output logic                  use_imm_o,
    output logic                  imm_sext_o,
    output logic                  slt_bias_o,
    output logic                  illegal_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        alu_ctrl_o = ALU_ADD;
        use_imm_o  = 1'b0;
        imm_sext_o = 1'b0;
        slt_bias_o = 1'b0;
        illegal_o  = 1'b0;

        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    F_ADD, F_ADDU: alu_ctrl_o = ALU_ADD;
                    F_SUB, F_SUBU: alu_ctrl_o = ALU_SUB;
                    F_AND:         alu_ctrl_o = ALU_AND;
                    F_OR:          alu_ctrl_o = ALU_OR;
                    F_NOR:         alu_ctrl_o = ALU_NOR;
                    F_SLT: begin
                        alu_ctrl_o = ALU_SLT;
                        slt_bias_o = 1'b1;
                    end
                    default:       illegal_o  = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                use_imm_o  = 1'b1;
                imm_sext_o = 1'b1;
            end
            OP_SLTI: begin
                alu_ctrl_o = ALU_SLT;
                use_imm_o  = 1'b1;
                imm_sext_o = 1'b1;
                slt_bias_o = 1'b1;
            end
            OP_ANDI: begin
                alu_ctrl_o = ALU_AND;
                use_imm_o  = 1'b1;
            end
            OP_ORI: begin
                alu_ctrl_o = ALU_OR;
                use_imm_o  = 1'b1;
            end
            // Branches compare rs/rt by subtraction; the ALU zero flag decides.
            OP_BEQ, OP_BNE: alu_ctrl_o = ALU_SUB;
            default:        illegal_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   ID/EX pipeline register feeding the combinational ALU: decodes the
//   instruction, selects/extends operands and registers them with a
//   valid/stall/flush handshake (flush > stall > load). Counts issues.
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active-low
//   bus   : alu_issue_if.master (id_* inputs, ex_stall/ex_flush, id_ready,
//           ex_valid, ex_alu_ctrl, ex_op_a, ex_op_b, ex_illegal, issue_count)
// ---------------------------------------------------------------------------
module alu_issue_stage
    import pipeline_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int N_ALU_CTRL = N_ALU_CTRL_DEF,
    parameter int N_CNT      = N_CNT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.master bus
);

    logic [N_ALU_CTRL-1:0] dec_ctrl;
    logic                  dec_use_imm;
    logic                  dec_imm_sext;
    logic                  dec_slt_bias;
    logic                  dec_illegal;

    alu_issue_decode #(.N_ALU_CTRL(N_ALU_CTRL)) u_decode (
        .opcode_i   (bus.id_opcode),
        .funct_i    (bus.id_funct),
        .alu_ctrl_o (dec_ctrl),
        .use_imm_o  (dec_use_imm),
        .imm_sext_o (dec_imm_sext),
        .slt_bias_o (dec_slt_bias),
        .illegal_o  (dec_illegal)
    );

    // Operand selection
    logic [N-1:0] imm_ext;
    logic [N-1:0] msb_flip;
    logic [N-1:0] op_a_sel;
    logic [N-1:0] op_b_sel;

    always_comb begin
        imm_ext  = dec_imm_sext ? {{(N-16){bus.id_imm16[15]}}, bus.id_imm16}
                                : {{(N-16){1'b0}}, bus.id_imm16};
        // Biasing both MSBs maps signed order onto unsigned order for SLT.
        msb_flip = dec_slt_bias ? {1'b1, {(N-1){1'b0}}} : '0;
        op_a_sel = bus.id_rs_data ^ msb_flip;
        op_b_sel = (dec_use_imm ? imm_ext : bus.id_rt_data) ^ msb_flip;
    end

    // ID/EX register
    logic                  valid_q,   valid_d;
    logic                  illegal_q, illegal_d;
    logic [N_ALU_CTRL-1:0] ctrl_q,    ctrl_d;
    logic [N-1:0]          op_a_q,    op_a_d;
    logic [N-1:0]          op_b_q,    op_b_d;
    logic [N_CNT-1:0]      cnt_q,     cnt_d;

    always_comb begin
        valid_d   = valid_q;
        illegal_d = illegal_q;
        ctrl_d    = ctrl_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        cnt_d     = cnt_q;

        if (bus.ex_flush) begin
            // Kill the entering instruction only; data and count hold.
            valid_d = 1'b0;
        end else if (!bus.ex_stall) begin
            valid_d = bus.id_valid;
            if (bus.id_valid) begin
                illegal_d = dec_illegal;
                ctrl_d    = dec_ctrl;
                op_a_d    = op_a_sel;
                op_b_d    = op_b_sel;
                cnt_d     = cnt_q + N_CNT'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!rst_n) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= ALU_ADD;
            op_a_q    <= '0;
            op_b_q    <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            ctrl_q    <= ctrl_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.id_ready    = ~bus.ex_stall;
    assign bus.ex_valid    = valid_q;
    assign bus.ex_illegal  = illegal_q;
    assign bus.ex_alu_ctrl = ctrl_q;
    assign bus.ex_op_a     = op_a_q;
    assign bus.ex_op_b     = op_b_q;
    assign bus.issue_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//   Self-checking bench: a table of decode vectors with hand-computed
//   expected ALU inputs is driven through a scoreboard queue, followed by
//   stall, bubble, flush and asynchronous-reset sequences.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

    localparam int N     = 32;
    localparam int N_CNT = 16;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } vec_t;

    logic clk;
    logic rst_n;

    alu_issue_if #(.N(N), .N_ALU_CTRL(4), .N_CNT(N_CNT)) bus ();

    alu_issue_stage #(.N(N), .N_ALU_CTRL(4), .N_CNT(N_CNT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    vec_t        sb[$];
    vec_t        last_exp;
    logic [15:0] exp_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic valid);
        bus.id_valid   = valid;
        bus.id_opcode  = v.op;
        bus.id_funct   = v.fn;
        bus.id_rs_data = v.rs;
        bus.id_rt_data = v.rt;
        bus.id_imm16   = v.imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare the held/loaded ALU inputs against a record.
    task automatic check_data(input string tag, input vec_t e);
        check({tag, ".ctrl"}, 64'(bus.ex_alu_ctrl), 64'(e.ctrl));
        check({tag, ".op_a"}, 64'(bus.ex_op_a),     64'(e.a));
        check({tag, ".op_b"}, 64'(bus.ex_op_b),     64'(e.b));
        check({tag, ".ill"},  64'(bus.ex_illegal),  64'(e.ill));
    endtask

    // Pop the oldest scoreboard entry and compare it with the EX outputs.
    task automatic pop_and_check(input string tag);
        vec_t e;
        check({tag, ".valid"}, 64'(bus.ex_valid), 64'(1));
        check({tag, ".count"}, 64'(bus.issue_count), 64'(exp_cnt));
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 64'(1), 64'(0));
        end else begin
            e = sb.pop_front();
            check_data(tag, e);
            last_exp = e;
        end
    endtask

    // Issue one instruction with no stall/flush; result visible next cycle.
    task automatic issue(input vec_t v, input string tag);
        drive(v, 1'b1);
        sb.push_back(v);
        exp_cnt = exp_cnt + 16'd1;
        step();
        pop_and_check(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".valid"}, 64'(bus.ex_valid),    64'(0));
        check({tag, ".ill"},   64'(bus.ex_illegal),  64'(0));
        check({tag, ".ctrl"},  64'(bus.ex_alu_ctrl), 64'(4'b0010));
        check({tag, ".op_a"},  64'(bus.ex_op_a),     64'(0));
        check({tag, ".op_b"},  64'(bus.ex_op_b),     64'(0));
        check({tag, ".count"}, 64'(bus.issue_count), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[19];
        vec_t vx;

        //          op     fn     rs            rt            imm       ctrl     a             b             ill
        vt[0]  = '{6'h00, 6'h20, 32'd5,        32'd7,        16'h0000, 4'b0010, 32'd5,        32'd7,        1'b0};
        vt[1]  = '{6'h08, 6'h3F, 32'd3,        32'h0000AAAA, 16'hFFFF, 4'b0010, 32'd3,        32'hFFFFFFFF, 1'b0};
        vt[2]  = '{6'h0C, 6'h00, 32'd3,        32'h0000AAAA, 16'hFFFF, 4'b0000, 32'd3,        32'h0000FFFF, 1'b0};
        vt[3]  = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1,        16'h0000, 4'b0111, 32'h7FFFFFFF, 32'h80000001, 1'b0};
        vt[4]  = '{6'h00, 6'h22, 32'd10,       32'd3,        16'h0000, 4'b0110, 32'd10,       32'd3,        1'b0};
        vt[5]  = '{6'h00, 6'h23, 32'd100,      32'd1,        16'h1234, 4'b0110, 32'd100,      32'd1,        1'b0};
        vt[6]  = '{6'h00, 6'h21, 32'd1,        32'd2,        16'h0000, 4'b0010, 32'd1,        32'd2,        1'b0};
        vt[7]  = '{6'h00, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0000, 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0};
        vt[8]  = '{6'h00, 6'h25, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0000, 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0};
        vt[9]  = '{6'h00, 6'h27, 32'h80000000, 32'h00000001, 16'h0000, 4'b1100, 32'h80000000, 32'h00000001, 1'b0};
        vt[10] = '{6'h0A, 6'h00, 32'd5,        32'h0000BEEF, 16'h8000, 4'b0111, 32'h80000005, 32'h7FFF8000, 1'b0};
        vt[11] = '{6'h0D, 6'h00, 32'd0,        32'h0000BEEF, 16'h8001, 4'b0001, 32'd0,        32'h00008001, 1'b0};
        vt[12] = '{6'h23, 6'h00, 32'h1000,     32'h0000BEEF, 16'h0004, 4'b0010, 32'h1000,     32'h00000004, 1'b0};
        vt[13] = '{6'h2B, 6'h00, 32'h2000,     32'h0000BEEF, 16'hFFFC, 4'b0010, 32'h2000,     32'hFFFFFFFC, 1'b0};
        vt[14] = '{6'h04, 6'h00, 32'd9,        32'd9,        16'h7777, 4'b0110, 32'd9,        32'd9,        1'b0};
        vt[15] = '{6'h05, 6'h00, 32'd9,        32'd8,        16'h7777, 4'b0110, 32'd9,        32'd8,        1'b0};
        vt[16] = '{6'h3F, 6'h00, 32'h11,       32'h22,       16'h0005, 4'b0010, 32'h11,       32'h22,       1'b1};
        vt[17] = '{6'h00, 6'h00, 32'h33,       32'h44,       16'h0005, 4'b0010, 32'h33,       32'h44,       1'b1};
        vt[18] = '{6'h00, 6'h2A, 32'd1,        32'h80000000, 16'h0000, 4'b0111, 32'h80000001, 32'h00000000, 1'b0};

        // Reset
        rst_n        = 1'b0;
        bus.ex_stall = 1'b0;
        bus.ex_flush = 1'b0;
        drive(vt[0], 1'b0);
        exp_cnt = '0;
        repeat (2) step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();
        check_reset_values("post_reset_idle");
        check("ready_idle", 64'(bus.id_ready), 64'(1));

        // Decode table, back-to-back issues
        for (int i = 0; i < 19; i++) begin
            issue(vt[i], $sformatf("vec%0d", i));
        end

        // Stall for 3 cycles with a new instruction waiting
        vx = '{6'h00, 6'h22, 32'd50, 32'd20, 16'h0000, 4'b0110, 32'd50, 32'd20, 1'b0};
        drive(vx, 1'b1);
        bus.ex_stall = 1'b1;
        #1;
        check("stall.ready", 64'(bus.id_ready), 64'(0));
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall%0d.ready", c), 64'(bus.id_ready), 64'(0));
            check($sformatf("stall%0d.valid", c), 64'(bus.ex_valid), 64'(1));
            check($sformatf("stall%0d.count", c), 64'(bus.issue_count), 64'(exp_cnt));
            check_data($sformatf("stall%0d", c), last_exp);
        end
        bus.ex_stall = 1'b0;
        #1;
        check("unstall.ready", 64'(bus.id_ready), 64'(1));
        sb.push_back(vx);
        exp_cnt = exp_cnt + 16'd1;
        step();
        pop_and_check("unstall");

        // Bubble: valid drops, data and count hold
        bus.id_valid = 1'b0;
        bus.id_rs_data = 32'hDEAD0000;
        step();
        check("bubble.valid", 64'(bus.ex_valid), 64'(0));
        check("bubble.count", 64'(bus.issue_count), 64'(exp_cnt));
        check_data("bubble", last_exp);

        // Flush together with stall: valid drops, nothing else changes
        issue(vt[0], "pre_flush");
        drive(vt[4], 1'b1);
        bus.ex_stall = 1'b1;
        bus.ex_flush = 1'b1;
        step();
        check("flush_stall.valid", 64'(bus.ex_valid), 64'(0));
        check("flush_stall.count", 64'(bus.issue_count), 64'(exp_cnt));
        check_data("flush_stall", last_exp);

        // Flush alone with a live ID instruction: it is not loaded
        bus.ex_stall = 1'b0;
        step();
        check("flush.valid", 64'(bus.ex_valid), 64'(0));
        check("flush.count", 64'(bus.issue_count), 64'(exp_cnt));
        check_data("flush", last_exp);
        bus.ex_flush = 1'b0;

        // Illegal opcode, then asynchronous reset mid-cycle
        issue(vt[16], "illegal");
        issue(vt[3], "before_reset");
        drive(vt[7], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        step();
        rst_n = 1'b1;
        sb.delete();
        exp_cnt = '0;
        bus.id_valid = 1'b0;
        step();
        check_reset_values("after_reset");
        issue(vt[0], "restart");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
